date_set_ctrl: RTL and testbench

Sequencing controller for the eight-digit BCD date display (DD.MM.YYYY). The block holds the date and advances it on a day tick, honouring month lengths. It also runs a mode/increment edit state machine for setting day, month and year. Its BCD digit outputs drive the existing bcd7seq decoders directly, one per HEX digit.

---
 rtl/date_ctrl_pkg.sv | 60 ++++++
 rtl/date_dim_lut.sv | 41 ++++
 rtl/date_set_ctrl.sv | 161 ++++++++++++++++
 tb/tb_date_set_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/date_ctrl_pkg.sv
// Shared types and constants for the DD.MM.YYYY date controller.
// Optional build macro LEAP_YEAR_EN (see date_dim_lut) enables 29 Feb in leap years.
package date_ctrl_pkg;

    // Encodings seen on EDIT_FIELD
    localparam logic [1:0] FIELD_RUN   = 2'd0;
    localparam logic [1:0] FIELD_DAY   = 2'd1;
    localparam logic [1:0] FIELD_MONTH = 2'd2;
    localparam logic [1:0] FIELD_YEAR  = 2'd3;

    // State encoding equals the field encoding so EDIT_FIELD is the state itself
    typedef enum logic [1:0] {
        ST_RUN   = FIELD_RUN,
        ST_DAY   = FIELD_DAY,
        ST_MONTH = FIELD_MONTH,
        ST_YEAR  = FIELD_YEAR
    } state_t;

    // Reset date (year comes from the YEAR_MIN parameter)
    localparam logic [7:0] RST_DAY   = 8'h01;
    localparam logic [7:0] RST_MONTH = 8'h01;

    localparam logic [7:0] MONTH_JAN = 8'h01;
    localparam logic [7:0] MONTH_FEB = 8'h02;
    localparam logic [7:0] MONTH_DEC = 8'h12;

    // Days-in-month values, BCD
    localparam logic [7:0] DIM_28 = 8'h28;
    localparam logic [7:0] DIM_29 = 8'h29;
    localparam logic [7:0] DIM_30 = 8'h30;
    localparam logic [7:0] DIM_31 = 8'h31;

    // Two-digit BCD increment (caller handles range wrap)
    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Four-digit BCD increment with digit-by-digit carry
    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/date_dim_lut.sv
// Days-in-month lookup on BCD month/year, shared by the tick-advance and
// edit-clamp paths. With LEAP_YEAR_EN defined, February gets 29 days in
// leap years decided purely on BCD digits; otherwise February is 28 days.
module date_dim_lut
    import date_ctrl_pkg::*;
(
    input  logic [7:0]  month_i,
`ifdef LEAP_YEAR_EN
    input  logic [15:0] year_i,
`endif
    output logic [7:0]  dim_o
);

    logic leap;

`ifdef LEAP_YEAR_EN
    // A two-digit BCD number is a multiple of 4 when an even tens digit pairs
    // with ones 0/4/8, or an odd tens digit pairs with ones 2/6.
    function automatic logic bcd_div4(input logic [3:0] tens, input logic [3:0] ones);
        if (tens[0]) return (ones == 4'd2) || (ones == 4'd6);
        else         return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
    endfunction

    // Century years (xx00) fall back to the century digits, so 2000 is leap
    assign leap = (year_i[7:0] != 8'h00) ? bcd_div4(year_i[7:4], year_i[3:0])
                                         : bcd_div4(year_i[15:12], year_i[11:8]);
`else
    assign leap = 1'b0;
`endif

    // Month length table
    always_comb begin
        dim_o = DIM_31;
        case (month_i)
            8'h04, 8'h06, 8'h09, 8'h11: dim_o = DIM_30;
            MONTH_FEB:                  dim_o = leap ? DIM_29 : DIM_28;
            default:                    dim_o = DIM_31;
        endcase
    end

endmodule

// File: rtl/date_set_ctrl.sv
// Date holder and edit controller for an eight-digit DD.MM.YYYY BCD display.
// Advances on DAY_TICK in RUN; KEY_MODE cycles RUN/day/month/year edit and
// KEY_INC bumps the selected field. Optional macro LEAP_YEAR_EN.
module date_set_ctrl
    import date_ctrl_pkg::*;
#(
    parameter logic [15:0] YEAR_MIN  = 16'h1999,
    parameter logic [15:0] YEAR_MAX  = 16'h2030,
    parameter int          BLINK_DIV = 25_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY_MODE,
    input  logic       KEY_INC,
    input  logic       DAY_TICK,
    output logic [3:0] G10,
    output logic [3:0] G1,
    output logic [3:0] A10,
    output logic [3:0] A1,
    output logic [3:0] Y1000,
    output logic [3:0] Y100,
    output logic [3:0] Y10,
    output logic [3:0] Y1,
    output logic [1:0] EDIT_FIELD,
    output logic       BLINK_ON
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_t             state_q, state_d;
    logic [7:0]         day_q, day_d;
    logic [7:0]         mon_q, mon_d;
    logic [15:0]        year_q, year_d;
    logic               blink_q, blink_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mode_sh_q, inc_sh_q;

    logic               mode_ev, inc_ev;
    logic [7:0]         day_inc, mon_nx, lut_month, dim;
    logic [15:0]        year_nx;

    // Bits [1:0] synchronise the key, bit 2 is the previous synchronised level
    assign mode_ev = mode_sh_q[1] & ~mode_sh_q[2];
    assign inc_ev  = inc_sh_q[1]  & ~inc_sh_q[2];

    assign day_inc = bcd_inc8(day_q);
    assign mon_nx  = (mon_q == MONTH_DEC) ? MONTH_JAN : bcd_inc8(mon_q);
    assign year_nx = (year_q == YEAR_MAX) ? YEAR_MIN : bcd_inc16(year_q);

    // The lookup sees the post-increment month/year while editing those
    // fields, so the clamp lands in the same cycle as the increment.
    assign lut_month = (state_q == ST_MONTH) ? mon_nx : mon_q;
`ifdef LEAP_YEAR_EN
    logic [15:0] lut_year;
    assign lut_year = (state_q == ST_YEAR) ? year_nx : year_q;
`endif

    date_dim_lut u_dim (
        .month_i (lut_month),
`ifdef LEAP_YEAR_EN
        .year_i  (lut_year),
`endif
        .dim_o   (dim)
    );

    // Key synchronisers and edge-detect history
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            mode_sh_q <= '0;
            inc_sh_q  <= '0;
        end else begin
            mode_sh_q <= {mode_sh_q[1:0], KEY_MODE};
            inc_sh_q  <= {inc_sh_q[1:0], KEY_INC};
        end
    end

    // State, date and blink registers
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= ST_RUN;
            day_q   <= RST_DAY;
            mon_q   <= RST_MONTH;
            year_q  <= YEAR_MIN;
            blink_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            day_q   <= day_d;
            mon_q   <= mon_d;
            year_q  <= year_d;
            blink_q <= blink_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: date update per mode, field sequencing, blink timing
    always_comb begin
        state_d = state_q;
        day_d   = day_q;
        mon_d   = mon_q;
        year_d  = year_q;
        blink_d = blink_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_RUN: begin
                if (DAY_TICK) begin
                    if (day_q < dim) begin
                        day_d = day_inc;
                    end else begin
                        day_d = RST_DAY;
                        mon_d = mon_nx;
                        if (mon_q == MONTH_DEC) year_d = year_nx;
                    end
                end
            end
            ST_DAY: begin
                if (inc_ev && !mode_ev) day_d = (day_q >= dim) ? RST_DAY : day_inc;
            end
            ST_MONTH: begin
                if (inc_ev && !mode_ev) begin
                    mon_d = mon_nx;
                    if (day_q > dim) day_d = dim;
                end
            end
            ST_YEAR: begin
                if (inc_ev && !mode_ev) begin
                    year_d = year_nx;
                    if (day_q > dim) day_d = dim;
                end
            end
            default: ;
        endcase

        if (mode_ev) begin
            case (state_q)
                ST_RUN:   state_d = ST_DAY;
                ST_DAY:   state_d = ST_MONTH;
                ST_MONTH: state_d = ST_YEAR;
                default:  state_d = ST_RUN;
            endcase
            cnt_d   = '0;
            blink_d = (state_q != ST_YEAR);
        end else if (state_q == ST_RUN) begin
            cnt_d   = '0;
            blink_d = 1'b0;
        end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign {G10, G1}             = day_q;
    assign {A10, A1}             = mon_q;
    assign {Y1000, Y100, Y10, Y1} = year_q;
    assign EDIT_FIELD            = state_q;
    assign BLINK_ON              = blink_q;

endmodule

// File: tb/tb_date_set_ctrl.sv
// Self-checking bench for date_set_ctrl: reference model on integer dates,
// table of tick transitions, directed corner sequences and random stimulus.
// Honours LEAP_YEAR_EN the same way as the design build.
module tb_date_set_ctrl;

    localparam int DIV = 6;

    logic       CLOCK_50 = 1'b0;
    logic       RESET = 1'b1, KEY_MODE = 1'b0, KEY_INC = 1'b0, DAY_TICK = 1'b0;
    logic [3:0] G10, G1, A10, A1, Y1000, Y100, Y10, Y1;
    logic [1:0] EDIT_FIELD;
    logic       BLINK_ON;
    logic [34:0] dut_vec;

    int total = 0;
    int bad   = 0;

    date_set_ctrl #(.YEAR_MIN(16'h1999), .YEAR_MAX(16'h2030), .BLINK_DIV(DIV)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY_MODE(KEY_MODE), .KEY_INC(KEY_INC),
        .DAY_TICK(DAY_TICK), .G10(G10), .G1(G1), .A10(A10), .A1(A1),
        .Y1000(Y1000), .Y100(Y100), .Y10(Y10), .Y1(Y1),
        .EDIT_FIELD(EDIT_FIELD), .BLINK_ON(BLINK_ON)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    assign dut_vec = {G10, G1, A10, A1, Y1000, Y100, Y10, Y1, EDIT_FIELD, BLINK_ON};

    // ---------------- reference model (integer calendar) ----------------
    int m_day, m_mon, m_year, m_field, m_since;
    bit pm1, pm2, pm3, pi1, pi2, pi3;   // key levels seen at the last three edges

    function automatic int dim_of(input int m, input int y);
        bit leap;
        leap = 1'b0;
`ifdef LEAP_YEAR_EN
        leap = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
`endif
        if (m == 2) return leap ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [31:0] bcd_date(input int d, input int m, input int y);
        return {4'(d / 10), 4'(d % 10), 4'(m / 10), 4'(m % 10),
                4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
    endfunction

    function automatic logic [34:0] model_vec();
        logic blink;
        blink = (m_field != 0) && (((m_since / DIV) % 2) == 0);
        return {bcd_date(m_day, m_mon, m_year), 2'(m_field), blink};
    endfunction

    task automatic model_step(input bit r, input bit km, input bit ki, input bit dt);
        bit mev, iev;
        if (r) begin
            m_day = 1; m_mon = 1; m_year = 1999; m_field = 0; m_since = 0;
            {pm1, pm2, pm3, pi1, pi2, pi3} = '0;
        end else begin
            mev = pm2 && !pm3;
            iev = pi2 && !pi3;
            pm3 = pm2; pm2 = pm1; pm1 = km;
            pi3 = pi2; pi2 = pi1; pi1 = ki;
            if (m_field == 0) begin
                if (dt) begin
                    if (m_day < dim_of(m_mon, m_year)) m_day++;
                    else begin
                        m_day = 1;
                        if (m_mon == 12) begin
                            m_mon  = 1;
                            m_year = (m_year == 2030) ? 1999 : m_year + 1;
                        end else m_mon++;
                    end
                end
            end else if (iev && !mev) begin
                case (m_field)
                    1: m_day = (m_day == dim_of(m_mon, m_year)) ? 1 : m_day + 1;
                    2: m_mon = (m_mon == 12) ? 1 : m_mon + 1;
                    default: m_year = (m_year == 2030) ? 1999 : m_year + 1;
                endcase
                if (m_day > dim_of(m_mon, m_year)) m_day = dim_of(m_mon, m_year);
            end
            if (mev) begin
                m_field = (m_field + 1) % 4;
                m_since = 0;
            end else if (m_field != 0) begin
                m_since++;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_date(input string name, input int d, input int m, input int y);
        check(name, 64'(dut_vec[34:3]), 64'(bcd_date(d, m, y)));
    endtask

    // One clock: drive inputs, advance model at the edge, compare just after it
    task automatic cyc(input bit r, input bit km, input bit ki, input bit dt);
        RESET = r; KEY_MODE = km; KEY_INC = ki; DAY_TICK = dt;
        @(posedge CLOCK_50);
        model_step(r, km, ki, dt);
        #1;
        check("model", 64'(dut_vec), 64'(model_vec()));
    endtask

    task automatic press_mode();
        cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    endtask

    task automatic press_inc();
        cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    // From reset, enter a date through the edit keys and return to RUN
    task automatic set_date(input int d, input int m, input int y);
        cyc(1, 0, 0, 0);
        press_mode(); press_mode();
        for (int i = 1; i < m; i++) press_inc();
        press_mode();
        for (int i = 1999; i < y; i++) press_inc();
        press_mode(); press_mode();
        for (int i = 1; i < d; i++) press_inc();
        press_mode(); press_mode(); press_mode();
        idle(3);
    endtask

    typedef struct {
        int d0, m0, y0;
        int d1, m1, y1;
    } vec_t;

    vec_t tbl[$];
    logic [34:0] rst_vec;
    int n;

    initial begin
        rst_vec = {bcd_date(1, 1, 1999), 2'd0, 1'b0};

        tbl.push_back('{31, 12, 2030,  1,  1, 1999});
        tbl.push_back('{30,  4, 2001,  1,  5, 2001});
        tbl.push_back('{31,  1, 2005,  1,  2, 2005});
        tbl.push_back('{28,  2, 2001,  1,  3, 2001});
        tbl.push_back('{ 9,  3, 2010, 10,  3, 2010});
        tbl.push_back('{29,  9, 2019, 30,  9, 2019});
        tbl.push_back('{30, 11, 2029,  1, 12, 2029});
`ifdef LEAP_YEAR_EN
        tbl.push_back('{28,  2, 2000, 29,  2, 2000});
        tbl.push_back('{29,  2, 2000,  1,  3, 2000});
        tbl.push_back('{28,  2, 2024, 29,  2, 2024});
`else
        tbl.push_back('{28,  2, 2000,  1,  3, 2000});
        tbl.push_back('{28,  2, 2024,  1,  3, 2024});
`endif

        // Reset state
        cyc(1, 0, 0, 0);
        check("reset_state", 64'(dut_vec), 64'(rst_vec));

        // Tick transitions from preset dates
        foreach (tbl[i]) begin
            set_date(tbl[i].d0, tbl[i].m0, tbl[i].y0);
            chk_date("preset", tbl[i].d0, tbl[i].m0, tbl[i].y0);
            cyc(0, 0, 0, 1);
            chk_date("tick_next", tbl[i].d1, tbl[i].m1, tbl[i].y1);
        end

        // Month edit clamps day 31 -> 28, exactly on the 3rd edge after key rise
        cyc(1, 0, 0, 0);
        press_mode();
        for (int i = 0; i < 30; i++) press_inc();
        press_mode();
        idle(3);
        check("month_field", 64'(EDIT_FIELD), 64'(2));
        chk_date("day31_preset", 31, 1, 1999);
        cyc(0, 0, 1, 0);
        chk_date("clamp_edge1", 31, 1, 1999);
        cyc(0, 0, 1, 0);
        chk_date("clamp_edge2", 31, 1, 1999);
        cyc(0, 0, 1, 0);
        chk_date("clamp_edge3", 28, 2, 1999);
        idle(3);

        // Mode and inc on the same cycle in EDIT_DAY: mode wins
        cyc(1, 0, 0, 0);
        press_mode();
        idle(3);
        cyc(0, 1, 1, 0);
        idle(4);
        check("mode_wins_field", 64'(EDIT_FIELD), 64'(2));
        chk_date("mode_wins_day", 1, 1, 1999);

        // DAY_TICK in EDIT_YEAR is dropped
        press_mode();
        idle(3);
        cyc(0, 0, 0, 1);
        idle(2);
        check("year_field", 64'(EDIT_FIELD), 64'(3));
        chk_date("tick_dropped", 1, 1, 1999);

        // Wait (bounded) for the blank phase, then reset mid-edit
        n = 0;
        while (BLINK_ON !== 1'b0 && n < 4 * DIV) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        check("blink_low_seen", 64'(BLINK_ON), 64'(0));
        cyc(1, 0, 0, 0);
        check("reset_mid_edit", 64'(dut_vec), 64'(rst_vec));

        // Tick and mode event on the same edge in RUN
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        check("tick_and_mode", 64'(dut_vec), 64'({bcd_date(2, 1, 1999), 2'd1, 1'b1}));
        idle(3);

        // Holding KEY_INC gives a single increment
        cyc(1, 0, 0, 0);
        press_mode();
        for (int i = 0; i < 4; i++) press_inc();
        idle(3);
        chk_date("hold_start", 5, 1, 1999);
        for (int i = 0; i < 100; i++) cyc(0, 0, 1, 0);
        idle(3);
        chk_date("hold_once", 6, 1, 1999);

        // Random traffic near the year wrap, compared against the model each cycle
        set_date(20, 12, 2030);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 599) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
